// File: rtl/apb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// apb_regfile_pkg
// Shared types and helpers for the APB register-file completer.
//   apb_rf_state_t : transfer FSM states (IDLE, WAIT, DONE)
//   apb_rf_err_t   : cause of an error response (kept for coverage/debug)
//   apb_rf_al()    : number of byte-offset address bits for a data width
// ---------------------------------------------------------------------------
package apb_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_rf_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_RO    = 2'd3
  } apb_rf_err_t;

  // Byte-offset bits inside one data word (0 for 8-bit, 1 for 16, 2 for 32).
  function automatic int apb_rf_al(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_regfile_slave_if.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave_if
// APB4 bus bundle between a requester and the register-file completer.
//   paddr/psel/penable/pwrite/pwdata/pstrb : requester -> completer
//   prdata/pready/pslverr                  : completer -> requester
// Modports: master (requester side), slave (completer side).
// ---------------------------------------------------------------------------
interface apb_regfile_slave_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_rf_mem.sv
// ---------------------------------------------------------------------------
// apb_rf_mem
// DEPTH x DATA_W storage with per-byte write enables and a synchronous
// read port. Contents are intentionally not reset.
//   pclk  : clock
//   we    : write enable; waddr/wdata/wstrb select word and byte lanes
//   re    : read enable; rdata <= mem[raddr] at the rising edge
// ---------------------------------------------------------------------------
module apb_rf_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                pclk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write: lanes whose strobe is low keep their old contents.
  always_ff @(posedge pclk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read; the caller only enables it for in-range indices.
  always_ff @(posedge pclk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
// APB4 completer in front of a word-addressed register array with
// configurable wait states, byte strobes, a read-only upper region,
// error responses (range / alignment / RO write), abort on psel drop and a
// saturating error counter.
//   pclk      : APB clock, rising edge
//   prst_n    : asynchronous active-low reset
//   bus       : APB signals (slave modport)
//   err_count : saturating count of completed errored transfers
// ---------------------------------------------------------------------------
module apb_regfile_slave
  import apb_regfile_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 256,
  parameter int RO_BASE     = 224,
  parameter int WAIT_CYCLES = 0,
  parameter int ERRCNT_W    = 8
) (
  input  logic                pclk,
  input  logic                prst_n,
  apb_regfile_slave_if.slave  bus,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int AL     = apb_rf_al(DATA_W);
  localparam int IDX_W  = ADDR_W - AL;
  localparam int STRB_W = DATA_W / 8;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << AL) - 1);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  apb_rf_state_t     state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              accept;

  logic [IDX_W-1:0]  setup_idx;
  apb_rf_err_t       setup_cause;

  logic [IDX_W-1:0]  idx_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  apb_rf_err_t       cause_q;
  logic              err_q;

  logic              wr_eff;
  logic              err_eff;
  logic              complete;
  logic              mem_we;
  logic              mem_re;
  logic [MEM_AW-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  assign setup_idx = bus.paddr[ADDR_W-1:AL];

  // Setup-phase decode. Range wins over alignment, alignment over RO, so the
  // recorded cause is the most fundamental reason the access is refused.
  always_comb begin
    setup_cause = ERR_NONE;
    if (32'(setup_idx) >= 32'(DEPTH)) begin
      setup_cause = ERR_RANGE;
    end else if ((bus.paddr & ALIGN_MASK) != '0) begin
      setup_cause = ERR_ALIGN;
    end else if (bus.pwrite && (32'(setup_idx) >= 32'(RO_BASE))) begin
      setup_cause = ERR_RO;
    end
  end

  // Next-state logic. WAIT aborts on psel drop; DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            count_d = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!bus.psel) begin
          state_d = IDLE;
        end else if (count_q == 4'd0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= IDLE;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Transfer context captured in the setup cycle.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      idx_q    <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      cause_q  <= ERR_NONE;
    end else if (accept) begin
      idx_q    <= setup_idx;
      pwrite_q <= bus.pwrite;
      pwdata_q <= bus.pwdata;
      pstrb_q  <= bus.pstrb;
      cause_q  <= setup_cause;
    end
  end

  assign err_q = (cause_q != ERR_NONE);

  // On the edge that enters DONE straight from IDLE the context registers
  // are still loading, so the read port must use the live setup decode.
  assign wr_eff    = (state_q == IDLE) ? bus.pwrite : pwrite_q;
  assign err_eff   = (state_q == IDLE) ? (setup_cause != ERR_NONE) : err_q;
  assign mem_raddr = (state_q == IDLE) ? setup_idx[MEM_AW-1:0] : idx_q[MEM_AW-1:0];
  assign mem_re    = (state_d == DONE) && !wr_eff && !err_eff;

  assign complete  = (state_q == DONE) && bus.psel && bus.penable;
  assign mem_we    = complete && pwrite_q && !err_q;

  apb_rf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .pclk  (pclk),
    .we    (mem_we),
    .waddr (idx_q[MEM_AW-1:0]),
    .wdata (pwdata_q),
    .wstrb (pstrb_q),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Response outputs are decoded from the DONE state register, so they
  // assert on the DONE-entry edge and clear as soon as reset hits.
  assign bus.pready  = (state_q == DONE);
  assign bus.pslverr = (state_q == DONE) && err_q;
  assign bus.prdata  = ((state_q == DONE) && !pwrite_q && !err_q) ? mem_rdata : '0;

  // Saturating error counter, bumped only on a completed errored transfer.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      err_count <= '0;
    end else if (complete && err_q && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_regfile_slave
// Directed bench for apb_regfile_slave. Three instances share one stimulus
// bus: dut0 (defaults), dut1 (WAIT_CYCLES=3), dut2 (ERRCNT_W=2). The active
// target is chosen by 'tgt'; psel is only asserted towards that instance.
// ---------------------------------------------------------------------------
module tb_apb_regfile_slave;
  import apb_regfile_pkg::*;

  logic        pclk;
  logic        prst_n;
  logic        prst_mid_n;
  int          tgt;
  logic [11:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic [7:0]  ec0;
  logic [7:0]  ec1;
  logic [1:0]  ec2;

  logic        cur_pready;
  logic        cur_pslverr;
  logic [31:0] cur_prdata;

  int          n_cmp;
  int          n_err;

  logic [31:0] rd;
  logic        err;
  int          waits;

  apb_regfile_slave_if #(.ADDR_W(12), .DATA_W(32)) if0 ();
  apb_regfile_slave_if #(.ADDR_W(12), .DATA_W(32)) if1 ();
  apb_regfile_slave_if #(.ADDR_W(12), .DATA_W(32)) if2 ();

  assign if0.paddr = paddr;   assign if1.paddr = paddr;   assign if2.paddr = paddr;
  assign if0.pwrite = pwrite; assign if1.pwrite = pwrite; assign if2.pwrite = pwrite;
  assign if0.pwdata = pwdata; assign if1.pwdata = pwdata; assign if2.pwdata = pwdata;
  assign if0.pstrb = pstrb;   assign if1.pstrb = pstrb;   assign if2.pstrb = pstrb;
  assign if0.penable = penable; assign if1.penable = penable; assign if2.penable = penable;
  assign if0.psel = psel && (tgt == 0);
  assign if1.psel = psel && (tgt == 1);
  assign if2.psel = psel && (tgt == 2);

  apb_regfile_slave dut0 (
    .pclk(pclk), .prst_n(prst_n), .bus(if0.slave), .err_count(ec0)
  );

  apb_regfile_slave #(.WAIT_CYCLES(3)) dut1 (
    .pclk(pclk), .prst_n(prst_n & prst_mid_n), .bus(if1.slave), .err_count(ec1)
  );

  apb_regfile_slave #(.ERRCNT_W(2)) dut2 (
    .pclk(pclk), .prst_n(prst_n), .bus(if2.slave), .err_count(ec2)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Response of whichever instance is currently targeted.
  always_comb begin
    cur_pready  = if0.pready;
    cur_pslverr = if0.pslverr;
    cur_prdata  = if0.prdata;
    case (tgt)
      1: begin
        cur_pready  = if1.pready;
        cur_pslverr = if1.pslverr;
        cur_prdata  = if1.prdata;
      end
      2: begin
        cur_pready  = if2.pready;
        cur_pslverr = if2.pslverr;
        cur_prdata  = if2.prdata;
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full APB transfer, entered and left at #1 after a rising edge.
  // Leaves the bus idle, so a following call starts a back-to-back setup.
  task automatic applyStimulus(input int t, input logic wr, input logic [11:0] addr,
                               input logic [31:0] wd, input logic [3:0] strb,
                               output logic [31:0] rdata, output logic rerr,
                               output int nwait);
    tgt = t; paddr = addr; pwrite = wr; pwdata = wd; pstrb = strb;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    nwait = 0;
    while (!cur_pready && nwait < 20) begin
      nwait++;
      @(posedge pclk); #1;
    end
    if (!cur_pready) checkOutput("pready_timeout", 32'(cur_pready), 32'd1);
    rdata = cur_prdata;
    rerr  = cur_pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    tgt = 0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0;
    prst_n = 1'b0; prst_mid_n = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    checkOutput("rst_pready",  32'(cur_pready),  32'd0);
    checkOutput("rst_pslverr", 32'(cur_pslverr), 32'd0);
    checkOutput("rst_prdata",  cur_prdata,       32'd0);
    checkOutput("rst_errcnt",  32'(ec0),         32'd0);
    checkOutput("rst_state",   32'(dut0.state_q), 32'(IDLE));
    prst_n = 1'b1;
    @(posedge pclk); #1;

    // Plain write then read with zero wait states.
    applyStimulus(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, err, waits);
    checkOutput("t1_wr_waits", 32'(waits), 32'd0);
    checkOutput("t1_wr_err",   32'(err),   32'd0);
    applyStimulus(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, waits);
    checkOutput("t1_rd_waits", 32'(waits), 32'd0);
    checkOutput("t1_rd_data",  rd,         32'hDEADBEEF);
    checkOutput("t1_rd_err",   32'(err),   32'd0);

    // Byte strobes: only lanes 0 and 2 take the new data.
    applyStimulus(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'hF, rd, err, waits);
    applyStimulus(0, 1'b1, 12'h020, 32'h11223344, 4'b0101, rd, err, waits);
    applyStimulus(0, 1'b0, 12'h020, 32'h0, 4'h0, rd, err, waits);
    checkOutput("t2_strb_data", rd, 32'hAA22CC44);

    // pstrb=0 write is OKAY and leaves the word alone.
    applyStimulus(0, 1'b1, 12'h010, 32'h00000000, 4'h0, rd, err, waits);
    checkOutput("t2_nostrb_err", 32'(err), 32'd0);
    applyStimulus(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, waits);
    checkOutput("t2_nostrb_data", rd, 32'hDEADBEEF);

    // Error responses: out of range, misaligned, RO write.
    dut0.u_mem.mem[230] <= 32'h12345678;
    @(posedge pclk); #1;
    applyStimulus(0, 1'b0, 12'h400, 32'h0, 4'h0, rd, err, waits);
    checkOutput("t3_range_err",  32'(err), 32'd1);
    checkOutput("t3_range_data", rd,       32'd0);
    applyStimulus(0, 1'b1, 12'h003, 32'hFFFFFFFF, 4'hF, rd, err, waits);
    checkOutput("t3_align_err", 32'(err), 32'd1);
    applyStimulus(0, 1'b1, 12'h398, 32'hFFFFFFFF, 4'hF, rd, err, waits);
    checkOutput("t3_ro_err", 32'(err), 32'd1);
    checkOutput("t3_errcnt", 32'(ec0), 32'd3);
    applyStimulus(0, 1'b0, 12'h398, 32'h0, 4'h0, rd, err, waits);
    checkOutput("t3_ro_rd_err",  32'(err), 32'd0);
    checkOutput("t3_ro_rd_data", rd,       32'h12345678);
    checkOutput("t3_errcnt_rd",  32'(ec0), 32'd3);

    // Back-to-back read, write, read with no idle cycles between them.
    applyStimulus(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, waits);
    checkOutput("t6_b2b_rd1", rd, 32'hDEADBEEF);
    checkOutput("t6_b2b_w1",  32'(waits), 32'd0);
    applyStimulus(0, 1'b1, 12'h030, 32'hCAFEF00D, 4'hF, rd, err, waits);
    checkOutput("t6_b2b_w2",  32'(waits), 32'd0);
    applyStimulus(0, 1'b0, 12'h030, 32'h0, 4'h0, rd, err, waits);
    checkOutput("t6_b2b_rd2", rd, 32'hCAFEF00D);
    checkOutput("t6_b2b_w3",  32'(waits), 32'd0);

    // Wait states: three low-pready access cycles, completion on the fourth.
    @(posedge pclk); #1;
    applyStimulus(1, 1'b1, 12'h050, 32'h0BADF00D, 4'hF, rd, err, waits);
    checkOutput("t4_wr_waits", 32'(waits), 32'd3);
    applyStimulus(1, 1'b0, 12'h050, 32'h0, 4'h0, rd, err, waits);
    checkOutput("t4_rd_waits", 32'(waits), 32'd3);
    checkOutput("t4_rd_data",  rd,         32'h0BADF00D);

    // Abort: psel dropped in the second access cycle of a write.
    tgt = 1; paddr = 12'h050; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    checkOutput("t4_abort_state", 32'(dut1.state_q), 32'(IDLE));
    applyStimulus(1, 1'b0, 12'h050, 32'h0, 4'h0, rd, err, waits);
    checkOutput("t4_abort_data", rd, 32'h0BADF00D);
    checkOutput("t4_abort_cnt",  32'(ec1), 32'd0);

    // Reset while a write sits in WAIT.
    applyStimulus(1, 1'b1, 12'h040, 32'h00000005, 4'hF, rd, err, waits);
    tgt = 1; paddr = 12'h040; pwrite = 1'b1; pwdata = 32'h00000099; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    checkOutput("t5_pre_state", 32'(dut1.state_q), 32'(WAIT));
    prst_mid_n = 1'b0;
    #1;
    checkOutput("t5_rst_pready",  32'(cur_pready),  32'd0);
    checkOutput("t5_rst_pslverr", 32'(cur_pslverr), 32'd0);
    checkOutput("t5_rst_prdata",  cur_prdata,       32'd0);
    checkOutput("t5_rst_state",   32'(dut1.state_q), 32'(IDLE));
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    prst_mid_n = 1'b1;
    @(posedge pclk); #1;
    applyStimulus(1, 1'b0, 12'h040, 32'h0, 4'h0, rd, err, waits);
    checkOutput("t5_after_data", rd, 32'h00000005);

    // Saturating counter on a 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2, 1'b0, 12'h400, 32'h0, 4'h0, rd, err, waits);
      if (i == 1) checkOutput("t6_sat_mid", 32'(ec2), 32'd2);
    end
    checkOutput("t6_sat_err",   32'(err), 32'd1);
    checkOutput("t6_sat_final", 32'(ec2), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
